// File: rtl/ch_collect_fsm.sv
// ch_collect_fsm
//   Receive-side reassembler for the channel priority serializer. Collects the
//   per-dump one-hot channel selections of one cycle, ORs them back into the
//   channel mask and flags malformed streams (non one-hot, out of order, stall).
//
// Ports
//   clk_i          clock, rising edge
//   reset_i        synchronous reset, active high
//   disable_i      abort to IDLE, clears accumulator and count (mask/errors kept)
//   start_i        opens (or restarts) a collection cycle
//   sel_valid_i    ch_sel_i is valid this cycle
//   ch_sel_i       one-hot selected channel, bit 0 = highest priority
//   cycle_done_i   transmitter closes the cycle
//   mask_o         reassembled mask, updated only on a clean cycle close
//   mask_valid_o   one-cycle pulse while mask_o carries a fresh mask
//   count_o        selections accepted in the current/last cycle
//   err_onehot_o   sticky: zero or multi-bit selection seen
//   err_order_o    sticky: selection index not strictly ascending
//   err_timeout_o  sticky: no event for TIMEOUT_CYCLES clocks in COLLECT
//   idle_o         registered, high while in IDLE
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start_i; stream inputs ignored
// COLLECT | accepting selections, checking order/one-hot, running the timer
// DONE    | single cycle, mask_o/mask_valid_o presented, then IDLE
// ERROR   | malformed stream seen; waits for start_i, errors held

module ch_collect_fsm #(
  parameter int CH_NUM         = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          disable_i,
  input  logic                          start_i,
  input  logic                          sel_valid_i,
  input  logic [CH_NUM-1:0]             ch_sel_i,
  input  logic                          cycle_done_i,
  output logic [CH_NUM-1:0]             mask_o,
  output logic                          mask_valid_o,
  output logic [$clog2(CH_NUM+1)-1:0]   count_o,
  output logic                          err_onehot_o,
  output logic                          err_order_o,
  output logic                          err_timeout_o,
  output logic                          idle_o
);

  localparam int CW = $clog2(CH_NUM + 1);
  localparam int IW = $clog2(CH_NUM);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [CW-1:0] COUNT_MAX  = CW'(CH_NUM);
  localparam bit            TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  // Last legal timer value; the cycle that finds the timer here is the
  // TIMEOUT_CYCLES-th quiet cycle and raises the timeout.
  localparam logic [TW-1:0] TIMER_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;
  localparam logic [1:0] ERROR   = 2'd3;

  logic [1:0]        state;
  logic [CH_NUM-1:0] acc;
  logic [IW-1:0]     last_idx;
  logic [TW-1:0]     timer;

  logic [IW-1:0]     sel_idx;
  logic              sel_onehot;
  logic              sel_order_bad;
  logic [CH_NUM-1:0] acc_with_sel;

  // One-hot to binary encode; only meaningful when the selection is one-hot.
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (ch_sel_i[i]) begin
        sel_idx = sel_idx | IW'(i);
      end
    end
  end

  assign sel_onehot    = ($countones(ch_sel_i) == 1);
  // count_o doubles as the "a selection was already accepted" flag, so the
  // first selection of a cycle skips the order check.
  assign sel_order_bad = (count_o != '0) && (sel_idx <= last_idx);
  assign acc_with_sel  = sel_valid_i ? (acc | ch_sel_i) : acc;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state         <= IDLE;
      acc           <= '0;
      last_idx      <= '0;
      timer         <= '0;
      mask_o        <= '0;
      mask_valid_o  <= 1'b0;
      count_o       <= '0;
      err_onehot_o  <= 1'b0;
      err_order_o   <= 1'b0;
      err_timeout_o <= 1'b0;
      idle_o        <= 1'b1;
    end else begin
      mask_valid_o <= 1'b0;
      if (disable_i) begin
        state   <= IDLE;
        acc     <= '0;
        count_o <= '0;
        idle_o  <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start_i) begin
              state         <= COLLECT;
              acc           <= '0;
              count_o       <= '0;
              last_idx      <= '0;
              timer         <= '0;
              err_onehot_o  <= 1'b0;
              err_order_o   <= 1'b0;
              err_timeout_o <= 1'b0;
              idle_o        <= 1'b0;
            end
          end

          COLLECT: begin
            if (start_i) begin
              // Restart: any selection presented alongside is dropped.
              acc      <= '0;
              count_o  <= '0;
              last_idx <= '0;
              timer    <= '0;
            end else if (sel_valid_i && !sel_onehot) begin
              err_onehot_o <= 1'b1;
              state        <= ERROR;
            end else if (sel_valid_i && sel_order_bad) begin
              err_order_o <= 1'b1;
              state       <= ERROR;
            end else begin
              if (sel_valid_i) begin
                acc      <= acc_with_sel;
                last_idx <= sel_idx;
                timer    <= '0;
                if (count_o != COUNT_MAX) begin
                  count_o <= count_o + 1'b1;
                end
              end
              if (cycle_done_i) begin
                state        <= DONE;
                mask_o       <= acc_with_sel;
                mask_valid_o <= 1'b1;
              end else if (!sel_valid_i && TIMEOUT_EN) begin
                if (timer == TIMER_LAST) begin
                  err_timeout_o <= 1'b1;
                  state         <= ERROR;
                end else begin
                  timer <= timer + 1'b1;
                end
              end
            end
          end

          DONE: begin
            state  <= IDLE;
            idle_o <= 1'b1;
          end

          ERROR: begin
            if (start_i) begin
              state         <= COLLECT;
              acc           <= '0;
              count_o       <= '0;
              last_idx      <= '0;
              timer         <= '0;
              err_onehot_o  <= 1'b0;
              err_order_o   <= 1'b0;
              err_timeout_o <= 1'b0;
            end
          end

          default: begin
            state  <= IDLE;
            idle_o <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ch_collect_fsm.sv
// tb_ch_collect_fsm
//   Directed bench for ch_collect_fsm. A queue-based model of the collection
//   cycle predicts every output on every clock; literal expectations pin the
//   model at the key points of each scenario. A second instance with the
//   timeout disabled shares the stimulus.

module tb_ch_collect_fsm;

  localparam int CH  = 16;
  localparam int TO  = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           disable_in;
  logic           start;
  logic           sel_valid;
  logic [CH-1:0]  ch_sel;
  logic           cycle_done;

  logic [CH-1:0]  mask;
  logic           mask_valid;
  logic [4:0]     count;
  logic           err_onehot, err_order, err_timeout, idle;

  logic [CH-1:0]  nt_mask;
  logic           nt_mask_valid;
  logic [4:0]     nt_count;
  logic           nt_err_onehot, nt_err_order, nt_err_timeout, nt_idle;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  ch_collect_fsm #(.CH_NUM(CH), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .reset_i(reset), .disable_i(disable_in), .start_i(start),
    .sel_valid_i(sel_valid), .ch_sel_i(ch_sel), .cycle_done_i(cycle_done),
    .mask_o(mask), .mask_valid_o(mask_valid), .count_o(count),
    .err_onehot_o(err_onehot), .err_order_o(err_order),
    .err_timeout_o(err_timeout), .idle_o(idle)
  );

  ch_collect_fsm #(.CH_NUM(CH), .TIMEOUT_CYCLES(0)) dut_nt (
    .clk_i(clk), .reset_i(reset), .disable_i(disable_in), .start_i(start),
    .sel_valid_i(sel_valid), .ch_sel_i(ch_sel), .cycle_done_i(cycle_done),
    .mask_o(nt_mask), .mask_valid_o(nt_mask_valid), .count_o(nt_count),
    .err_onehot_o(nt_err_onehot), .err_order_o(nt_err_order),
    .err_timeout_o(nt_err_timeout), .idle_o(nt_idle)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_COLL, M_DONE, M_ERR} phase_t;
  phase_t  m_phase;
  int      accepted[$];   // channel indices accepted in the current cycle
  int      quiet;         // consecutive collecting clocks without an event
  int      idx;
  bit      bad;
  logic [CH-1:0] m_mask;
  bit      m_valid, m_eoh, m_eord, m_eto;

  function automatic logic [CH-1:0] mask_of_accepted();
    logic [CH-1:0] m = '0;
    foreach (accepted[i]) m[accepted[i]] = 1'b1;
    return m;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_phase = M_IDLE; accepted.delete(); quiet = 0;
      m_mask = '0; m_valid = 0; m_eoh = 0; m_eord = 0; m_eto = 0;
    end else begin
      m_valid = 0;
      if (disable_in) begin
        m_phase = M_IDLE;
        accepted.delete();
      end else begin
        case (m_phase)
          M_IDLE: if (start) begin
            m_phase = M_COLL; accepted.delete(); quiet = 0;
            m_eoh = 0; m_eord = 0; m_eto = 0;
          end
          M_COLL: begin
            if (start) begin
              accepted.delete(); quiet = 0;
            end else begin
              bad = 0;
              if (sel_valid) begin
                if ($countones(ch_sel) != 1) begin
                  m_eoh = 1; bad = 1;
                end else begin
                  idx = $clog2(ch_sel);
                  if (accepted.size() > 0 && idx <= accepted[$]) begin
                    m_eord = 1; bad = 1;
                  end else begin
                    accepted.push_back(idx); quiet = 0;
                  end
                end
              end
              if (bad) m_phase = M_ERR;
              else if (cycle_done) begin
                m_phase = M_DONE; m_mask = mask_of_accepted(); m_valid = 1;
              end else if (!sel_valid) begin
                quiet++;
                if (TO != 0 && quiet >= TO) begin
                  m_eto = 1; m_phase = M_ERR;
                end
              end
            end
          end
          M_DONE: m_phase = M_IDLE;
          M_ERR: if (start) begin
            m_phase = M_COLL; accepted.delete(); quiet = 0;
            m_eoh = 0; m_eord = 0; m_eto = 0;
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mdl_mask",       mask,        m_mask);
      chk("mdl_mask_valid", mask_valid,  m_valid);
      chk("mdl_count",      count,       accepted.size());
      chk("mdl_err_onehot", err_onehot,  m_eoh);
      chk("mdl_err_order",  err_order,   m_eord);
      chk("mdl_err_timeout",err_timeout, m_eto);
      chk("mdl_idle",       idle,        (m_phase == M_IDLE));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic st, input logic sv, input logic [CH-1:0] cs,
                     input logic cd, input logic dis);
    start = st; sel_valid = sv; ch_sel = cs; cycle_done = cd; disable_in = dis;
    @(negedge clk);
  endtask

  task automatic nop();
    cyc(0, 0, '0, 0, 0);
  endtask

  task automatic sel(input logic [CH-1:0] cs);
    cyc(0, 1, cs, 0, 0);
  endtask

  initial begin
    reset = 1; disable_in = 0; start = 0; sel_valid = 0; ch_sel = '0; cycle_done = 0;
    @(negedge clk); @(negedge clk);
    chk_en = 1'b1;
    chk("rst_idle",  idle,  1);
    chk("rst_mask",  mask,  0);
    chk("rst_count", count, 0);
    reset = 0;

    // 1: two selections then close
    cyc(1, 0, '0, 0, 0);
    sel(16'h0002); sel(16'h0020);
    chk("t1_valid_early", mask_valid, 0);
    cyc(0, 0, '0, 1, 0);
    chk("t1_valid", mask_valid, 1);
    chk("t1_mask",  mask,  16'h0022);
    chk("t1_count", count, 2);
    chk("t1_errs",  {err_onehot, err_order, err_timeout}, 0);
    nop();
    chk("t1_valid_off", mask_valid, 0);
    chk("t1_idle", idle, 1);

    // 2: five selections, last one with cycle_done
    cyc(1, 0, '0, 0, 0);
    sel(16'h0040); sel(16'h1000); sel(16'h2000); sel(16'h4000);
    cyc(0, 1, 16'h8000, 1, 0);
    chk("t2_mask",  mask,  16'hF040);
    chk("t2_count", count, 5);
    chk("t2_valid", mask_valid, 1);
    nop();

    // 3: descending order, ignored close in ERROR, restart, duplicate
    cyc(1, 0, '0, 0, 0);
    sel(16'h0020); sel(16'h0002);
    chk("t3_order", err_order, 1);
    chk("t3_mask_kept", mask, 16'hF040);
    cyc(0, 0, '0, 1, 0);
    chk("t3_no_valid", mask_valid, 0);
    cyc(1, 0, '0, 0, 0);
    chk("t3_order_clr", err_order, 0);
    chk("t3_not_idle", idle, 0);
    sel(16'h0020); sel(16'h0020);
    chk("t3_dup", err_order, 1);

    // 4: multi-bit and zero selections
    cyc(1, 0, '0, 0, 0);
    sel(16'h0011);
    chk("t4_multi", err_onehot, 1);
    cyc(1, 0, '0, 0, 0);
    chk("t4_clr", err_onehot, 0);
    sel(16'h0000);
    chk("t4_zero", err_onehot, 1);

    // empty cycle, then restart discarding a simultaneous selection
    cyc(1, 0, '0, 0, 0);
    cyc(0, 0, '0, 1, 0);
    chk("empty_valid", mask_valid, 1);
    chk("empty_mask",  mask, 0);
    chk("empty_count", count, 0);
    nop();
    cyc(1, 0, '0, 0, 0);
    sel(16'h0008);
    cyc(1, 1, 16'h0001, 0, 0);
    sel(16'h0004);
    cyc(0, 0, '0, 1, 0);
    chk("restart_mask",  mask,  16'h0004);
    chk("restart_count", count, 1);
    nop();

    // 5: timeout after 8 quiet clocks; disabled timeout never fires
    cyc(1, 0, '0, 0, 0);
    for (int i = 1; i <= TO; i++) begin
      nop();
      chk($sformatf("t5_to_%0d", i), err_timeout, (i == TO));
    end
    chk("t5_nt_alive", nt_err_timeout, 0);
    cyc(1, 0, '0, 0, 0);
    for (int i = 0; i < 100; i++) nop();
    chk("t5_nt_timeout", nt_err_timeout, 0);
    chk("t5_nt_collect", nt_idle, 0);
    chk("t5_to_set", err_timeout, 1);

    // 6: disable together with cycle_done, then reset mid-cycle
    cyc(1, 0, '0, 0, 0);
    sel(16'h0004);
    cyc(0, 0, '0, 1, 1);
    chk("t6_no_valid", mask_valid, 0);
    chk("t6_idle",  idle,  1);
    chk("t6_count", count, 0);
    chk("t6_mask_kept", mask, 16'h0004);
    nop();
    cyc(1, 0, '0, 0, 0);
    sel(16'h0001);
    sel(16'h0011);
    chk("t6_err_before_rst", err_onehot, 1);
    reset = 1;
    nop();
    chk("t6_rst_mask",  mask,  0);
    chk("t6_rst_count", count, 0);
    chk("t6_rst_errs",  {err_onehot, err_order, err_timeout}, 0);
    chk("t6_rst_idle",  idle,  1);
    reset = 0;
    nop(); nop();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ch_collect_fsm.md
Name: ch_collect_fsm

Overview:
- Receive-side counterpart of the channel priority serializer.
- Accepts the stream of one-hot channel selections emitted per dump, together with the end-of-cycle indication, and reassembles them into the original channel mask.
- Checks that the stream is well formed: one-hot, strictly ascending priority order (bit 0 highest priority), and no stall.
- Sits downstream of the serializer in the coder datapath and feeds the reassembled mask, its selection count and error flags to the readout/status logic.

Parameters:
CH_NUM, 16, number of channels; width of ch_sel_i and mask_o.
TIMEOUT_CYCLES, 64, maximum clocks between events in COLLECT before a timeout error; 0 disables the timeout.

Ports:
clk_i  input  1  clock; all logic on the rising edge.
reset_i  input  1  synchronous reset, active-high.
disable_i  input  1  abort: forces IDLE and clears the accumulator; has priority over every input except reset_i.
start_i  input  1  opens a collection cycle (receive-side image of arm).
sel_valid_i  input  1  strobe; ch_sel_i is valid this cycle.
ch_sel_i  input  CH_NUM  one-hot selected channel.
cycle_done_i  input  1  transmitter indicates the cycle is complete.
mask_o  output  CH_NUM  reassembled mask; registered, held until the next DONE.
mask_valid_o  output  1  one-cycle pulse when mask_o updates.
count_o  output  $clog2(CH_NUM+1)  selections accepted in the current/last cycle.
err_onehot_o  output  1  sticky: a zero or multi-bit selection was received.
err_order_o  output  1  sticky: a selection index was <= the previous index in this cycle.
err_timeout_o  output  1  sticky: the timeout expired in COLLECT.
idle_o  output  1  high in IDLE.

Behaviour:
- Reset (reset_i high at an edge): state IDLE, accumulator = 0, mask_o = 0, mask_valid_o = 0, count_o = 0, all err_* = 0, idle_o = 1, last-index register cleared, timeout counter = 0.
- States: IDLE, COLLECT, DONE, ERROR.
- IDLE:
  - start_i -> COLLECT; clears accumulator, count_o, err_*, last index and timeout counter.
  - sel_valid_i and cycle_done_i are ignored.
- COLLECT, on sel_valid_i:
  - ch_sel_i not one-hot (zero or more than one bit): set err_onehot_o -> ERROR.
  - Index <= last accepted index (a duplicate counts as out of order): set err_order_o -> ERROR.
  - Otherwise: OR the bit into the accumulator, increment count_o, store the index, reset the timeout counter.
  - The first selection of a cycle has no order check.
- COLLECT, on cycle_done_i:
  - -> DONE.
  - If sel_valid_i is high in the same cycle and the selection is valid, it is included before closing.
  - If the selection is erroneous, ERROR wins.
- COLLECT, start_i (restart): clears the accumulator, count, last index and timer; stays in COLLECT. Any simultaneous sel_valid_i is discarded.
- COLLECT, timeout: the counter increments every COLLECT cycle with no accepted event. When it reaches TIMEOUT_CYCLES-1, set err_timeout_o -> ERROR. With TIMEOUT_CYCLES = 0 the counter is inert.
- DONE (exactly one cycle):
  - mask_o = accumulator and mask_valid_o = 1 during this cycle, i.e. one clock after the edge that sampled cycle_done_i.
  - -> IDLE unconditionally; inputs in DONE are ignored.
- An empty cycle (cycle_done_i with no selections) is legal: mask_o = 0, count_o = 0, mask_valid_o pulses.
- ERROR:
  - mask_o is not updated; mask_valid_o stays 0.
  - err_* hold their values.
  - start_i -> COLLECT with errors cleared.
  - All other inputs are ignored.
- disable_i:
  - Any state -> IDLE next cycle; accumulator and count cleared.
  - mask_o and err_* are kept.
  - No mask_valid_o pulse, even if cycle_done_i is simultaneous.
- Reset mid-cycle: reset_i overrides everything; outputs return to reset values on the next edge.
- count_o saturates structurally at CH_NUM; the order check prevents exceeding it.
- Index extraction is a combinational one-hot to binary encode of width $clog2(CH_NUM). Only the order check uses it.
- idle_o = (state == IDLE), registered.

Test Plan:
1. Reset, start_i, selections 0x0002 then 0x0020, cycle_done_i -> mask_valid_o pulses once, one clock after cycle_done_i; mask_o = 0x0022; count_o = 2; err_* = 0; then idle_o = 1.
2. start_i, selections 0x0040, 0x1000, 0x2000, 0x4000 then 0x8000 with cycle_done_i on the same cycle as the last -> mask_o = 0xF040, count_o = 5.
3. start_i, selections 0x0020 then 0x0002 -> err_order_o = 1, ERROR, no mask_valid_o, mask_o keeps 0xF040. Then start_i -> errors clear, COLLECT.
4. start_i, selection 0x0011 -> err_onehot_o = 1. A following selection of 0x0000 in a new cycle also sets err_onehot_o.
5. TIMEOUT_CYCLES = 8: start_i, then no events for 8 clocks -> err_timeout_o rises at the 8th clock, ERROR. With TIMEOUT_CYCLES = 0, waiting 100 clocks raises no error.
6. start_i, selection 0x0004, then disable_i together with cycle_done_i -> IDLE, no mask_valid_o, count_o = 0. Also: reset_i asserted mid-COLLECT returns all outputs to reset values.
